// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch stage.
//   fault_e        - fault tag carried with every fetched entry
//   fetch_entry_t  - one prefetch FIFO record {pc, inst, fault}
//   fetch_state_e  - fetch control state (RUN / HALT)
//   fault_check()  - classifies a fetch address before it is pushed
package fetch_pkg;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2
    } fault_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        fault_e      fault;
    } fetch_entry_t;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    // Value presented to decode while nothing is queued.
    localparam fetch_entry_t ENTRY_EMPTY = '{pc: 32'h0000_0000, inst: INST_NOP, fault: FLT_NONE};

    // Misalignment wins over range. The offset is pc - ROM_BASE, so an address
    // below the base wraps to a huge offset and is caught by the same compare.
    function automatic fault_e fault_check(input logic [31:0] pc,
                                           input logic [31:0] offset,
                                           input logic [31:0] rom_bytes);
        fault_e f;
        if (pc[1:0] != 2'b00) begin
            f = FLT_MISALIGN;
        end else if (offset >= rom_bytes) begin
            f = FLT_RANGE;
        end else begin
            f = FLT_NONE;
        end
        return f;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO with a registered head.
//   clk, reset_n      - clock, async active-low reset
//   flush             - clear pointers/count (wins over push/pop)
//   push, wdata       - enqueue; accepted when not full or when popping
//   pop               - dequeue head; ignored when empty
//   full              - count == DEPTH
//   head_valid, head  - registered head entry; EMPTY value when nothing queued
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    parameter T    EMPTY = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output logic full,
    output logic head_valid,
    output T     head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T                mem_r [DEPTH];
    T                mem_n [DEPTH];
    logic [AW-1:0]   wr_ptr_r, wr_ptr_n;
    logic [AW-1:0]   rd_ptr_r, rd_ptr_n;
    logic [CW-1:0]   count_r, count_n;
    T                head_r, head_n;
    logic            head_valid_r;
    logic            push_ok_s, pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign pop_ok_s  = pop & (count_r != CW'(0));
    // Push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok_s = push & (~full | pop_ok_s);

    // Next-state of storage, pointers and count; head is computed from the next
    // state so the registered head is ready the cycle after a push into empty.
    always_comb begin
        mem_n    = mem_r;
        wr_ptr_n = wr_ptr_r;
        rd_ptr_n = rd_ptr_r;
        count_n  = count_r;
        if (flush) begin
            wr_ptr_n = AW'(0);
            rd_ptr_n = AW'(0);
            count_n  = CW'(0);
        end else begin
            if (push_ok_s) begin
                mem_n[wr_ptr_r] = wdata;
                wr_ptr_n        = wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_n = wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_n = rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_n = count_r + CW'(1);
                2'b01:   count_n = count_r - CW'(1);
                default: count_n = count_r;
            endcase
        end
        if (count_n != CW'(0)) begin
            head_n = mem_n[rd_ptr_n];
        end else begin
            head_n = EMPTY;
        end
    end

    // State registers: storage, pointers, count and the registered head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= EMPTY;
            end
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            count_r      <= CW'(0);
            head_r       <= EMPTY;
            head_valid_r <= 1'b0;
        end else begin
            mem_r        <= mem_n;
            wr_ptr_r     <= wr_ptr_n;
            rd_ptr_r     <= rd_ptr_n;
            count_r      <= count_n;
            head_r       <= head_n;
            head_valid_r <= (count_n != CW'(0));
        end
    end

    assign head       = head_r;
    assign head_valid = head_valid_r;

endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: fetch stage between PC logic and decode.
//   clk, reset_n                 - clock, async active-low reset
//   fetch_en                     - permit new fetches (FIFO drains regardless)
//   rom_addr / rom_inst          - combinational ROM port (byte offset from ROM_BASE)
//   redirect_valid / redirect_pc - flush queued entries and restart at a new PC
//   if_valid/if_ready            - handshake to decode
//   if_pc/if_inst/if_fault       - head entry (NOP + fault tag on a bad fetch)
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int          ROM_WORDS = 512,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  if_fault
);

    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

    logic [31:0]  fetch_pc_r;
    fetch_state_e state_r;
    logic [31:0]  offset_s;
    fault_e       fault_s;
    logic         push_s, pop_s, full_s, head_valid_s;
    fetch_entry_t entry_s, head_s;

    assign offset_s = fetch_pc_r - ROM_BASE;
    assign rom_addr = offset_s[11:0];
    assign fault_s  = fault_check(fetch_pc_r, offset_s, ROM_BYTES);

    // Redirect blocks both sides of the FIFO in its cycle; the flush does the rest.
    assign pop_s  = head_valid_s & if_ready & ~redirect_valid;
    assign push_s = (state_r == FS_RUN) & fetch_en & ~redirect_valid & (~full_s | pop_s);

    // Entry to enqueue: faulting fetches carry a NOP so decode never sees ROM garbage.
    always_comb begin
        entry_s.pc    = fetch_pc_r;
        entry_s.fault = fault_s;
        if (fault_s == FLT_NONE) begin
            entry_s.inst = rom_inst;
        end else begin
            entry_s.inst = INST_NOP;
        end
    end

    // Fetch PC and RUN/HALT control; a fault parks the PC on the bad address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= RESET_PC;
            state_r    <= FS_RUN;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            state_r    <= FS_RUN;
        end else if (push_s) begin
            if (fault_s == FLT_NONE) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
                state_r    <= state_r;
            end else begin
                fetch_pc_r <= fetch_pc_r;
                state_r    <= FS_HALT;
            end
        end else begin
            fetch_pc_r <= fetch_pc_r;
            state_r    <= state_r;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t),
        .EMPTY (ENTRY_EMPTY)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push_s),
        .wdata      (entry_s),
        .pop        (pop_s),
        .full       (full_s),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

    assign if_valid = head_valid_s;
    assign if_pc    = head_s.pc;
    assign if_inst  = head_s.inst;
    assign if_fault = head_s.fault;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [11:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  if_fault;

    logic [31:0] rom [512];

    int total = 0;
    int bad   = 0;

    // reference model: queue of delivered-to-be entries plus fetch PC and halt flag
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;

    typedef struct {
        bit          rst;
        bit          fe;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl[24];

    inst_fetch_buffer #(
        .RESET_PC  (32'h0000_0000),
        .ROM_BASE  (32'h0000_0000),
        .ROM_WORDS (512),
        .DEPTH     (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb rom_inst = rom[rom_addr[10:2]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0000_0000;
        m_halt = 1'b0;
    endtask

    task automatic model_step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit   do_pop, do_push;
        ent_t e;
        if (rv) begin
            mq.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = !m_halt && fe && ((mq.size() < 4) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc = m_pc;
                if (m_pc % 4 != 0)          e.fault = 2'd1;
                else if (m_pc >= 32'h800)   e.fault = 2'd2;
                else                        e.fault = 2'd0;
                e.inst = (e.fault != 2'd0) ? NOP : rom[m_pc / 4];
                mq.push_back(e);
                if (e.fault != 2'd0) m_halt = 1'b1;
                else                 m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        logic        ev;
        logic [31:0] epc, einst;
        logic [1:0]  ef;
        if (mq.size() > 0) begin
            ev = 1'b1; epc = mq[0].pc; einst = mq[0].inst; ef = mq[0].fault;
        end else begin
            ev = 1'b0; epc = 32'h0; einst = NOP; ef = 2'd0;
        end
        chk("model_outputs", {if_valid, if_pc, if_inst, if_fault, rom_addr},
            {ev, epc, einst, ef, m_pc[11:0]});
    endtask

    // one cycle: check at negedge, drive inputs, step the model at the edge
    task automatic cyc(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
        check_model();
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        model_step(fe, rdy, rv, rpc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        model_reset();
        chk("reset_values", {if_valid, if_pc, if_inst, if_fault, rom_addr},
            {1'b0, 32'h0, NOP, 2'd0, 12'h000});
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input bit rst, input bit fe, input bit rdy, input bit rv,
                                input logic [31:0] rpc, input bit ev, input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
        return v;
    endfunction

    initial begin
        logic [31:0] rpc;
        bit          fe, rdy, rv;

        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 512; i++) rom[i] = $urandom();
        model_reset();

        // streaming from reset, then backpressure fill, full push+pop, redirect to 0x40
        tbl[0] = mk(1, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[1] = mk(0, 1, 1, 0, 32'h0, 1, 32'h0);
        tbl[2] = mk(0, 1, 1, 0, 32'h0, 1, 32'h4);
        tbl[3] = mk(0, 1, 1, 0, 32'h0, 1, 32'h8);
        tbl[4] = mk(0, 1, 1, 0, 32'h0, 1, 32'hC);
        tbl[5] = mk(1, 1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 6; i <= 14; i++) tbl[i] = mk(0, 1, 0, 0, 32'h0, 1, 32'h0);
        tbl[15] = mk(0, 1, 1, 0, 32'h0, 1, 32'h0);
        tbl[16] = mk(0, 1, 1, 0, 32'h0, 1, 32'h4);
        tbl[17] = mk(0, 1, 1, 0, 32'h0, 1, 32'h8);
        tbl[18] = mk(0, 1, 1, 0, 32'h0, 1, 32'hC);
        tbl[19] = mk(0, 1, 1, 0, 32'h0, 1, 32'h10);
        tbl[20] = mk(0, 1, 1, 1, 32'h40, 1, 32'h14);
        tbl[21] = mk(0, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[22] = mk(0, 1, 1, 0, 32'h0, 1, 32'h40);
        tbl[23] = mk(0, 1, 1, 0, 32'h0, 1, 32'h44);

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].rst) do_reset();
            chk($sformatf("tbl%0d_valid", i), if_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].epc);
            if (i == 14) chk("full_hold_rom_addr", rom_addr, 12'h010);
            cyc(tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
        end

        // misaligned redirect: one fault entry, then silence until redirect to 0x8
        cyc(1, 1, 1, 32'h42);
        chk("mis_gap_valid", if_valid, 1'b0);
        cyc(1, 1, 0, 32'h0);
        chk("mis_entry", {if_valid, if_pc, if_inst, if_fault}, {1'b1, 32'h42, NOP, 2'd1});
        cyc(1, 1, 0, 32'h0);
        chk("mis_halt_valid0", if_valid, 1'b0);
        cyc(1, 1, 0, 32'h0);
        chk("mis_halt_valid1", if_valid, 1'b0);
        cyc(1, 1, 1, 32'h8);
        cyc(1, 1, 0, 32'h0);
        chk("resume_8", {if_valid, if_pc, if_inst, if_fault}, {1'b1, 32'h8, rom[2], 2'd0});

        // end of ROM: 0x7FC normal, 0x800 range fault, then halt
        cyc(1, 1, 1, 32'h7F8);
        cyc(1, 1, 0, 32'h0);
        chk("end_7f8", {if_valid, if_pc}, {1'b1, 32'h7F8});
        cyc(1, 1, 0, 32'h0);
        chk("end_7fc", {if_valid, if_pc, if_inst, if_fault}, {1'b1, 32'h7FC, rom[511], 2'd0});
        cyc(1, 1, 0, 32'h0);
        chk("range_800", {if_valid, if_pc, if_inst, if_fault}, {1'b1, 32'h800, NOP, 2'd2});
        cyc(1, 1, 0, 32'h0);
        chk("range_halt0", if_valid, 1'b0);
        cyc(1, 1, 0, 32'h0);
        chk("range_halt1", if_valid, 1'b0);

        // mid-stream asynchronous reset
        cyc(1, 1, 1, 32'h0);
        cyc(1, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        chk("pre_async_valid", if_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_out", {if_valid, if_pc, if_inst, if_fault},
               {1'b0, 32'h0, NOP, 2'd0});
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            fe  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 4))
                0:       rpc = 32'($urandom_range(0, 511)) * 32'd4;
                1:       rpc = 32'h7F0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       rpc = 32'($urandom_range(0, 511)) * 32'd4 + 32'($urandom_range(1, 3));
                3:       rpc = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
                default: rpc = 32'($urandom_range(0, 31)) * 32'd4;
            endcase
            cyc(fe, rdy, rv, rpc);
        end
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
